sync_fifo_prog: RTL and testbench

// Single-clock, parametrised successor to our ASYNIC_FIFO.
// - Generalised width/depth; programmable ALMOST_FULL/ALMOST_EMPTY thresholds; live fill COUNT.
// - Sticky OVERFLOW/UNDERFLOW error flags with clear; selectable standard or first-word-fall-through read mode.
// - Used wherever producer and consumer share one clock; no CDC synchronisers inside.
//

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem_dp.sv | 23 ++
 rtl/sync_fifo_prog.sv | 114 +++++++++++
 tb/tb_sync_fifo_prog.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
package fifo_pkg;

  localparam int unsigned MODE_STD      = 0;
  localparam int unsigned MODE_FWFT     = 1;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem_dp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-flags, live count, sticky error
// flags and selectable standard or first-word-fall-through read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_width   = DEFAULT_WIDTH,
  parameter int unsigned FIFO_depth   = DEFAULT_DEPTH,
  parameter int unsigned Pointer_Size = clog2(FIFO_depth) + 1,
  parameter int unsigned FWFT         = MODE_STD
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    W_INC,
  input  logic [FIFO_width-1:0]   WR_DATA,
  input  logic                    R_INC,
  output logic [FIFO_width-1:0]   RD_DATA,
  output logic                    FULL,
  output logic                    EMPTY,
  input  logic [Pointer_Size-1:0] AF_THRESH,
  input  logic [Pointer_Size-1:0] AE_THRESH,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [Pointer_Size-1:0] COUNT,
  input  logic                    CLR_ERR,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int unsigned AW = Pointer_Size - 1;
  localparam logic [Pointer_Size-1:0] DEPTH_P = Pointer_Size'(FIFO_depth);

  logic [Pointer_Size-1:0] wptr_q, wptr_d;
  logic [Pointer_Size-1:0] rptr_q, rptr_d;
  logic [Pointer_Size-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    udf_q, udf_d;
  logic                    wr_en, rd_en;
  logic [FIFO_width-1:0]   mem_rdata;

  // Flags are pure decodes of the registered fill count.
  assign FULL         = (count_q == DEPTH_P);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AF_THRESH);
  assign ALMOST_EMPTY = (count_q <= AE_THRESH);
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

  assign wr_en = W_INC & ~FULL;
  assign rd_en = R_INC & ~EMPTY;

  // Pointer, count and sticky-error next state; a new error beats a clear.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (wr_en) wptr_d = wptr_q + Pointer_Size'(1);
    if (rd_en) rptr_d = rptr_q + Pointer_Size'(1);
    if (wr_en && !rd_en)      count_d = count_q + Pointer_Size'(1);
    else if (rd_en && !wr_en) count_d = count_q - Pointer_Size'(1);
    if (CLR_ERR) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (W_INC && FULL)  ovf_d = 1'b1;
    if (R_INC && EMPTY) udf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (FIFO_width),
    .DEPTH (FIFO_depth),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (wr_en),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (WR_DATA),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == MODE_STD) begin : g_std
    logic [FIFO_width-1:0] rd_data_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST)        rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem_rdata;
    end

    assign RD_DATA = rd_data_q;
  end else begin : g_fwft
    // Head word shown directly; forced to zero while empty so reset reads 0.
    assign RD_DATA = EMPTY ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: standard and FWFT instances driven by one directed stream.
module tb_sync_fifo_prog;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       W_INC = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       R_INC = 1'b0;
  logic [3:0] AF_THRESH = 4'd6;
  logic [3:0] AE_THRESH = 4'd1;
  logic       CLR_ERR = 1'b0;

  logic [7:0] s_rd, f_rd;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_count, f_count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] exp_s;
  logic       s_pending = 1'b0;

  always #5 CLK = ~CLK;

  sync_fifo_prog #(.FIFO_width(8), .FIFO_depth(8), .Pointer_Size(4), .FWFT(0)) dut_std (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC),
    .RD_DATA(s_rd), .FULL(s_full), .EMPTY(s_empty), .AF_THRESH(AF_THRESH),
    .AE_THRESH(AE_THRESH), .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae), .COUNT(s_count),
    .CLR_ERR(CLR_ERR), .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
  );

  sync_fifo_prog #(.FIFO_width(8), .FIFO_depth(8), .Pointer_Size(4), .FWFT(1)) dut_fwft (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC),
    .RD_DATA(f_rd), .FULL(f_full), .EMPTY(f_empty), .AF_THRESH(AF_THRESH),
    .AE_THRESH(AE_THRESH), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .COUNT(f_count),
    .CLR_ERR(CLR_ERR), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; push records a write expected to be accepted.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic clr, input logic push);
    W_INC = w; WR_DATA = d; R_INC = r; CLR_ERR = clr;
    if (push) begin
      q_s.push_back(d);
      q_f.push_back(d);
    end
    @(posedge CLK);
    #1;
    W_INC = 1'b0; R_INC = 1'b0; CLR_ERR = 1'b0;
  endtask

  // Read acceptance pops the scoreboard; standard data is checked half a cycle later.
  always @(posedge CLK) begin
    if (!RST) begin
      if (R_INC && !s_empty) begin
        if (q_s.size() == 0) chk("std_unexpected_read", 32'h1, 32'h0);
        else begin
          exp_s = q_s.pop_front();
          s_pending = 1'b1;
        end
      end
      if (R_INC && !f_empty) begin
        if (q_f.size() == 0) chk("fwft_unexpected_read", 32'h1, 32'h0);
        else void'(q_f.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (s_pending) begin
        chk("rd_std", 32'(s_rd), 32'(exp_s));
        s_pending = 1'b0;
      end
      if (!f_empty) begin
        if (q_f.size() == 0) chk("fwft_head_missing", 32'h1, 32'h0);
        else chk("rd_fwft_head", 32'(f_rd), 32'(q_f[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset values
    #1;
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_ae",    32'(s_ae),    32'd1);
    chk("rst_af",    32'(s_af),    32'd0);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_udf",   32'(s_udf),   32'd0);
    chk("rst_rd",    32'(s_rd),    32'd0);
    @(posedge CLK); #1; RST = 1'b0;

    // Reset mid-stream: 3 writes, 1 read, then async reset between edges
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_count", 32'(s_count), 32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_count", 32'(s_count), 32'd0);
    chk("mid_rst_empty", 32'(s_empty), 32'd1);
    chk("mid_rst_full",  32'(s_full),  32'd0);
    chk("mid_rst_rd",    32'(s_rd),    32'd0);
    chk("mid_rst_rd_f",  32'(f_rd),    32'd0);
    q_s.delete(); q_f.delete(); s_pending = 1'b0;
    @(posedge CLK); #1; RST = 1'b0;

    // Fill 0x01..0x08 with flag checks after each write
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
      chk("fill_count", 32'(s_count), 32'(k));
      chk("fill_ae",    32'(s_ae),    32'(k <= 1));
      chk("fill_af",    32'(s_af),    32'(k >= 6));
      chk("fill_full",  32'(s_full),  32'(k == 8));
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set",    32'(s_ovf),   32'd1);
    chk("ovf_count",  32'(s_count), 32'd8);

    // Drain; scoreboard checks 0x01..0x08
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_empty",   32'(s_empty), 32'd1);
    chk("drain_empty_f", 32'(f_empty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("udf_set", 32'(s_udf), 32'd1);
    @(negedge CLK);
    chk("udf_rd_hold", 32'(s_rd), 32'h08);

    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_udf", 32'(s_udf), 32'd0);

    // First-word-fall-through
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("fwft_empty_fall", 32'(f_empty), 32'd0);
    chk("fwft_show",       32'(f_rd),    32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fwft_pop_empty",  32'(f_empty), 32'd1);

    // Simultaneous write+read at FULL
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b1);
    chk("full2", 32'(s_full), 32'd1);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("simfull_count", 32'(s_count), 32'd7);
    chk("simfull_ovf",   32'(s_ovf),   32'd1);

    // Simultaneous at COUNT=4 across the pointer wrap
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mid_count", 32'(s_count), 32'd4);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'(8'h20 + k), 1'b1, 1'b0, 1'b1);
      chk("sim4_count", 32'(s_count), 32'd4);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 32'(s_empty), 32'd1);

    // Simultaneous at EMPTY
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    chk("simempty_count", 32'(s_count), 32'd1);
    chk("simempty_udf",   32'(s_udf),   32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr2_ovf", 32'(s_ovf), 32'd0);
    chk("clr2_udf", 32'(s_udf), 32'd0);

    // Clear coincident with a new overflow: set wins
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("setwins_ovf",   32'(s_ovf),   32'd1);
    chk("setwins_ovf_f", 32'(f_ovf),   32'd1);
    chk("setwins_udf",   32'(s_udf),   32'd0);
    chk("setwins_count", 32'(s_count), 32'd8);

    // Threshold above depth never asserts ALMOST_FULL
    AF_THRESH = 4'd9;
    #1;
    chk("af_over_depth", 32'(s_af), 32'd0);
    AF_THRESH = 4'd6;
    #1;
    chk("af_restore", 32'(s_af), 32'd1);

    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("final_empty", 32'(s_empty), 32'd1);
    chk("final_sb",    32'(q_s.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
